add_round_key_pipe: RTL

Parametrised, flow-controlled AES AddRoundKey stage for the AES-128 datapath. Holds a loadable round-key register, XORs each accepted data block with it, and queues results in a small output FIFO. The stage therefore applies backpressure to the round pipeline instead of dropping blocks. Adds per-block bypass, key zeroization and residue-free output, none of which the fixed single-register stage provides.

---
 rtl/add_round_key_pipe.sv | 96 +++++++++
 1 files changed

// File: rtl/add_round_key_pipe.sv
`default_nettype none
// =============================================================================
// add_round_key_pipe : AES AddRoundKey stage with key register and output FIFO
// Rev 1.0
// =============================================================================
module add_round_key_pipe #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_clear_in,
    output logic              key_loaded_out,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bypass_in,
    output logic              data_ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  count_out
);

    localparam int               PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] key_q, key_d;
    logic              key_loaded_q, key_loaded_d;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;
    logic [DATA_W-1:0] push_data;

    assign data_ready_out = (count_q < C_FULL) & (key_loaded_q | bypass_in);
    assign valid_out      = (count_q != '0);
    assign data_out       = valid_out ? fifo_q[rd_ptr_q] : '0;
    assign key_loaded_out = key_loaded_q;
    assign count_out      = count_q;

    assign push      = data_valid_in & data_ready_out;
    assign pop       = valid_out & ready_in;
    // Uses the key as it stands before this edge, so a same-cycle load applies to the next block
    assign push_data = bypass_in ? data_in : (data_in ^ key_q);

    always_comb begin
        key_d        = key_q;
        key_loaded_d = key_loaded_q;
        if (key_clear_in) begin
            key_d        = '0;
            key_loaded_d = 1'b0;
        end else if (key_valid_in) begin
            key_d        = key_in;
            key_loaded_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            key_q        <= key_d;
            key_loaded_q <= key_loaded_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule
`default_nettype wire
